wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the register-file write port among NUM_REQ writeback sources (ALU, load unit, ...).
//  Arbitrates pending requests, registers the winner into a one-entry output stage and drives
//  the write port: destination index, data and the one-hot per-register write enable.
//  Sits between the execute/memory units and the register file, upstream of the write port.
// PARAMETERS
//  NUM_REQ      4   number of requesters (2..8)
//  DATA_WIDTH   16  register data width
//  ADDR_WIDTH   4   register index width; register count = 2**ADDR_WIDTH
//  ZERO_REG_RO  0   1: writes to register 0 are acked but discarded
// PORTS
//  clk       in   1                    clock, rising edge
//  reset     in   1                    asynchronous, active-low reset
//  req       in   NUM_REQ              request per source; held until acked
//  reqDest   in   NUM_REQ*ADDR_WIDTH   destination index, source i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  reqData   in   NUM_REQ*DATA_WIDTH   write data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//  ack       out  NUM_REQ              one-cycle grant pulse, combinational, at most one bit set
//  wrValid   out  1                    write port holds a valid write
//  wrReady   in   1                    register file accepts the write this cycle
//  wrDest    out  ADDR_WIDTH           destination index of the current write
//  wrData    out  DATA_WIDTH           data of the current write
//  wrDecOut  out  2**ADDR_WIDTH        one-hot of wrDest when wrValid, else all zero
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): wrValid=0, wrDest=0, wrData=0, wrDecOut=0, priority pointer=0,
//    stage FSM=EMPTY. ack is forced to 0 while reset is low. A pending entry is dropped and not acked.
//  - Output-stage FSM has two states. EMPTY means wrValid=0; FULL means wrValid=1.
//  - Accept condition: acc = (EMPTY) | (FULL & wrReady).
//  - Grant: if acc and |req, the winner w is chosen and ack[w]=1 in the same cycle.
//    At the rising edge the winner's reqDest/reqData load into wrDest/wrData, and wrDecOut loads 1<<dest.
//  - The stage then goes to FULL. Exception: the discarded register-0 case below.
//  - If acc and no req: the stage goes to EMPTY (wrValid=0, wrDecOut=0).
//    wrDest and wrData keep their last values.
//  - FULL & !wrReady: all outputs hold stable and ack=0 (back-pressure; no grant).
//  - Latency: request at cycle t with acc=1 gives wrValid=1 at t+1.
//    Throughput is one write per cycle while wrReady=1.
//  - Requester handshake: source i drives req[i]/reqDest/reqData stable until it samples ack[i]=1 at an edge.
//    It may present a new request on the next cycle. Dropping req before ack is illegal.
//  - ZERO_REG_RO=1 and winner dest==0: ack is issued and the pointer advances.
//    The stage does not load and ends EMPTY.
//  - Priority pointer p (0..NUM_REQ-1): the search order is p, p+1, ... modulo NUM_REQ.
//    On a grant to w, p becomes (w+1) mod NUM_REQ, with wrap-around from NUM_REQ-1 to 0.
//    p is unchanged when no grant occurs.
//  - Simultaneous drain and refill (FULL & wrReady & |req) keeps the stage FULL with the new entry, with no bubble.
//  - Same destination from two sources in consecutive grants: both writes are issued in grant order. No merging.
// CONFIGURATION
//  WBARB_ROUND_ROBIN_EN defined: rotating priority pointer as described above.
//  WBARB_ROUND_ROBIN_EN undefined: fixed priority, where the lowest asserted index always wins and p is held at 0.
//    All other behaviour is identical.
// TESTING
//  Test configuration: NUM_REQ=4, DATA_WIDTH=16, ADDR_WIDTH=4, wrReady=1, round-robin enabled unless stated.
//  1. Reset: assert reset=0 mid-write with wrValid=1.
//     -> wrValid=0, wrDecOut=16'h0000 and ack=0 immediately. After release the first grant goes to req[0].
//  2. Single request: req=4'b0010, dest=4'hA, data=16'h1234 at t.
//     -> ack=4'b0010 at t. At t+1: wrValid=1, wrDest=4'hA, wrData=16'h1234, wrDecOut=16'h0400.
//  3. Round-robin: req=4'b1111 held, each source re-requesting after its ack.
//     -> grants go 0,1,2,3,0 on consecutive cycles.
//     Without WBARB_ROUND_ROBIN_EN the grants are 0,0,0,...
//  4. Back-pressure: wrReady=0 for 3 cycles with req=4'b0100 pending.
//     -> outputs frozen and ack=0 for those cycles. ack[2]=1 in the cycle wrReady returns to 1, with no lost write.
//  5. Zero register: ZERO_REG_RO=1 and req[1] with dest=0.
//     -> ack[1]=1, wrValid stays 0, and the next grant starts at source 2.
//  6. Back-to-back: req[3] dest=5 then dest=5 again, data 16'h00AA then 16'h00BB.
//     -> two writes on consecutive cycles in that order, each with wrDecOut=16'h0020.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates NUM_REQ writeback sources onto one register-file write port (WBARB_ROUND_ROBIN_EN selects rotating priority, else fixed).
// Latency: ack is combinational in the grant cycle; the write is presented on wrValid one cycle later, one write per cycle.
// Backpressure: a held write with wrReady=0 freezes the output stage and suppresses every ack.
module wb_port_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter bit ZERO_REG_RO = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqDest,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          wrValid,
    input  logic                          wrReady,
    output logic [ADDR_WIDTH-1:0]         wrDest,
    output logic [DATA_WIDTH-1:0]         wrData,
    output logic [(2**ADDR_WIDTH)-1:0]    wrDecOut
);
    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_t;

    stage_t                  state;
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        next_ptr;
    logic [ADDR_WIDTH-1:0]   win_dest;
    logic [DATA_WIDTH-1:0]   win_data;
    logic [NUM_REQ-1:0]      grant_vec;
    logic [NUM_REGS-1:0]     win_dec;
    logic                    acc;
    logic                    found;
    logic                    discard;
`ifdef WBARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0]        win_idx;
`endif

    assign acc = (state == EMPTY) || wrReady;

    // Pass 0 scans indices at or above the pointer, pass 1 wraps to the lowest index.
    always_comb begin
        found     = 1'b0;
        win_dest  = '0;
        win_data  = '0;
        grant_vec = '0;
`ifdef WBARB_ROUND_ROBIN_EN
        win_idx   = '0;
`endif
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (pass == 1 || PTR_W'(i) >= ptr)) begin
                    found        = 1'b1;
                    win_dest     = reqDest[i*ADDR_WIDTH +: ADDR_WIDTH];
                    win_data     = reqData[i*DATA_WIDTH +: DATA_WIDTH];
                    grant_vec[i] = 1'b1;
`ifdef WBARB_ROUND_ROBIN_EN
                    win_idx      = PTR_W'(i);
`endif
                end
            end
        end
    end

    always_comb begin
        win_dec           = '0;
        win_dec[win_dest] = 1'b1;
    end

`ifdef WBARB_ROUND_ROBIN_EN
    assign next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
`else
    assign next_ptr = '0;
`endif

    assign discard = ZERO_REG_RO && (win_dest == '0);
    assign ack     = (reset && acc) ? grant_vec : '0;
    assign wrValid = (state == FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            ptr      <= '0;
            wrDest   <= '0;
            wrData   <= '0;
            wrDecOut <= '0;
        end else if (acc) begin
            if (found) begin
                ptr <= next_ptr;
                if (discard) begin
                    // Register 0 is read-only: the source is acked but nothing reaches the port.
                    state    <= EMPTY;
                    wrDecOut <= '0;
                end else begin
                    state    <= FULL;
                    wrDest   <= win_dest;
                    wrData   <= win_data;
                    wrDecOut <= win_dec;
                end
            end else begin
                state    <= EMPTY;
                wrDecOut <= '0;
            end
        end
    end
endmodule
